// File: rtl/dsp_pkg.sv
// Shared types and constants for the DSP48A1 multiply-accumulate sequencer.
// Latency: none (declarations only).
// Backpressure: not applicable.
package dsp_pkg;

   localparam int A_W = 18;
   localparam int P_W = 48;

   localparam logic [7:0] OPM_MUL_FIRST = 8'h01;  // X=M, Z=0
   localparam logic [7:0] OPM_MUL_ACC   = 8'h09;  // X=M, Z=P
   localparam logic [7:0] OPM_MUL_BIAS  = 8'h0D;  // X=M, Z=C

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } state_t;

   // Tag carried down the opmode line for every cycle slot.
   typedef struct packed {
      logic vld;
      logic first;
   } opm_tag_t;

   // OPMODE for a real term: the first term of a job starts the accumulation.
   function automatic logic [7:0] opm_encode(input logic first);
`ifdef DSP_MAC_BIAS_EN
      return first ? OPM_MUL_BIAS : OPM_MUL_ACC;
`else
      return first ? OPM_MUL_FIRST : OPM_MUL_ACC;
`endif
   endfunction

endpackage

// File: rtl/dsp_tag_delay.sv
// Fixed-depth shift register for per-cycle tags, synchronous clear.
// Latency: DEPTH cycles from din to dout.
// Backpressure: none; shifts every cycle.
module dsp_tag_delay #(
   parameter int DEPTH = 1,
   parameter int W     = 1
) (
   input  logic         clk,
   input  logic         clr,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);

   logic [W-1:0] stage [DEPTH];

   // Shift one slot per cycle; clear empties every slot.
   always_ff @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else begin
         stage[0] <= din;
         for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end

   assign dout = stage[DEPTH-1];

endmodule

// File: rtl/dsp_mac_seq.sv
// Sequences a DSP48A1 slice as a MAC over a job of LEN operand pairs; optional bias via DSP_MAC_BIAS_EN.
// Latency: result valid P_DLY+1 cycles after the last accepted pair (LEN=0: the cycle after START).
// Backpressure: IN_READY only in RUN; result held in DONE until RES_READY.
module dsp_mac_seq
   import dsp_pkg::*;
#(
   parameter int LEN_W  = 10,
   parameter int OP_DLY = 1,
   parameter int P_DLY  = 2
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic [LEN_W-1:0] LEN,
   output logic             BUSY,
   input  logic [A_W-1:0]   IN_A,
   input  logic [A_W-1:0]   IN_B,
   input  logic             IN_VALID,
   output logic             IN_READY,
   output logic [P_W-1:0]   RES_DATA,
   output logic             RES_VALID,
   input  logic             RES_READY,
   output logic [A_W-1:0]   DSP_A,
   output logic [A_W-1:0]   DSP_B,
   output logic             DSP_CEAB,
   output logic [7:0]       DSP_OPMODE,
   output logic             DSP_CEOPMODE,
   output logic             DSP_CEP,
   output logic             DSP_RSTP,
`ifdef DSP_MAC_BIAS_EN
   input  logic [P_W-1:0]   BIAS,
   output logic [P_W-1:0]   DSP_C,
`endif
   input  logic [P_W-1:0]   DSP_P
);

   localparam int DR_W = $clog2(P_DLY + 1);

   state_t           state, state_nxt;
   logic [LEN_W-1:0] term_cnt;
   logic [DR_W-1:0]  drain_cnt;
   logic             first_pend;
   logic             acc;
   logic [P_W-1:0]   empty_res;
   opm_tag_t         opl_in, opl_out;
   logic             enl_out;
   logic [7:0]       opm_hold;

   assign acc = IN_VALID & IN_READY;

`ifdef DSP_MAC_BIAS_EN
   assign DSP_C     = BIAS;
   assign empty_res = BIAS;
`else
   assign empty_res = '0;
`endif

   // State register.
   always_ff @(posedge CLK) begin
      if (RST) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Next-state decode and state-derived handshake outputs.
   always_comb begin
      state_nxt = state;
      BUSY      = 1'b1;
      IN_READY  = 1'b0;
      case (state)
         ST_IDLE: begin
            BUSY = 1'b0;
            if (START) state_nxt = (LEN == '0) ? ST_DONE : ST_RUN;
         end
         ST_RUN: begin
            IN_READY = 1'b1;
            if (acc && term_cnt == LEN_W'(1)) state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (drain_cnt == '0) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            if (RES_READY) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Term/drain counters, first-term flag and the result register.
   always_ff @(posedge CLK) begin
      if (RST) begin
         term_cnt   <= '0;
         drain_cnt  <= '0;
         first_pend <= 1'b0;
         RES_DATA   <= '0;
         RES_VALID  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (START) begin
                  if (LEN != '0) begin
                     term_cnt   <= LEN;
                     first_pend <= 1'b1;
                  end else begin
                     // Empty job: the slice is never touched.
                     RES_DATA  <= empty_res;
                     RES_VALID <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (acc) begin
                  term_cnt   <= term_cnt - LEN_W'(1);
                  first_pend <= 1'b0;
                  if (term_cnt == LEN_W'(1)) drain_cnt <= DR_W'(P_DLY);
               end
            end
            ST_DRAIN: begin
               if (drain_cnt == '0) begin
                  RES_DATA  <= DSP_P;
                  RES_VALID <= 1'b1;
               end else begin
                  drain_cnt <= drain_cnt - DR_W'(1);
               end
            end
            ST_DONE: begin
               if (RES_READY) RES_VALID <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign opl_in = {acc, first_pend};

   dsp_tag_delay #(.DEPTH(OP_DLY), .W($bits(opm_tag_t))) u_opm_line (
      .clk  (CLK),
      .clr  (RST),
      .din  (opl_in),
      .dout (opl_out)
   );

   dsp_tag_delay #(.DEPTH(P_DLY), .W(1)) u_en_line (
      .clk  (CLK),
      .clr  (RST),
      .din  (acc),
      .dout (enl_out)
   );

   // Remember the last issued OPMODE so empty slots keep presenting it.
   always_ff @(posedge CLK) begin
      if (RST) opm_hold <= '0;
      else     opm_hold <= DSP_OPMODE;
   end

   // The opmode line's final stage is the register; a real tag overrides the held value.
   assign DSP_OPMODE   = opl_out.vld ? opm_encode(opl_out.first) : opm_hold;
   assign DSP_CEP      = enl_out;
   assign DSP_CEOPMODE = 1'b1;
   assign DSP_RSTP     = RST;
   assign DSP_A        = IN_A;
   assign DSP_B        = IN_B;
   assign DSP_CEAB     = acc;

endmodule

// File: tb/tb_dsp_mac_seq.sv
// Bench for dsp_mac_seq with a behavioural DSP48A1 slice attached.
// Latency: n/a.
// Backpressure: RES_READY driven by the stimulus process.
module tb_dsp_mac_seq;

   localparam int LEN_W = 10;
`ifdef DSP_MAC_BIAS_EN
   localparam logic [7:0] FIRST_OPM = 8'h0D;
`else
   localparam logic [7:0] FIRST_OPM = 8'h01;
`endif

   logic             CLK, RST, START, BUSY, IN_VALID, IN_READY;
   logic [LEN_W-1:0] LEN;
   logic [17:0]      IN_A, IN_B, DSP_A, DSP_B;
   logic [47:0]      RES_DATA, DSP_P;
   logic             RES_VALID, RES_READY, DSP_CEAB, DSP_CEOPMODE, DSP_CEP, DSP_RSTP;
   logic [7:0]       DSP_OPMODE;
`ifdef DSP_MAC_BIAS_EN
   logic [47:0]      BIAS, DSP_C;
`endif

   dsp_mac_seq dut (
      .CLK(CLK), .RST(RST), .START(START), .LEN(LEN), .BUSY(BUSY),
      .IN_A(IN_A), .IN_B(IN_B), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
      .RES_DATA(RES_DATA), .RES_VALID(RES_VALID), .RES_READY(RES_READY),
      .DSP_A(DSP_A), .DSP_B(DSP_B), .DSP_CEAB(DSP_CEAB), .DSP_OPMODE(DSP_OPMODE),
      .DSP_CEOPMODE(DSP_CEOPMODE), .DSP_CEP(DSP_CEP), .DSP_RSTP(DSP_RSTP),
`ifdef DSP_MAC_BIAS_EN
      .BIAS(BIAS), .DSP_C(DSP_C),
`endif
      .DSP_P(DSP_P)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Behavioural DSP48A1: A1/B1 regs, M reg, OPMODE reg, P reg with CEP.
   logic signed [17:0] s_a1, s_b1;
   logic signed [35:0] s_m;
   logic [7:0]         s_opm;
   logic [47:0]        s_p, s_c, s_x, s_z;

   always_comb begin
      s_x = (s_opm[1:0] == 2'b01) ? {{12{s_m[35]}}, s_m} : 48'd0;
      case (s_opm[3:2])
         2'b10:   s_z = s_p;
         2'b11:   s_z = s_c;
         default: s_z = 48'd0;
      endcase
   end

   always @(posedge CLK) begin
      if (DSP_CEAB) begin
         s_a1 <= DSP_A;
         s_b1 <= DSP_B;
      end
`ifdef DSP_MAC_BIAS_EN
      s_c <= DSP_C;
`else
      s_c <= 48'd0;
`endif
      if (DSP_RSTP) begin
         s_m   <= '0;
         s_opm <= '0;
         s_p   <= '0;
      end else begin
         s_m   <= s_a1 * s_b1;
         s_opm <= DSP_OPMODE;
         if (DSP_CEP) s_p <= s_x + s_z;
      end
   end
   assign DSP_P = s_p;

   typedef struct {
      logic [47:0] data;
      int          cyc;
      int          cep;
   } exp_t;

   exp_t        sb[$];
   logic [17:0] qa[$], qb[$];
   int          vectors = 0, miscompares = 0;
   int          cyc = 0, cep_total = 0;
   logic        seen = 1'b0;
   logic [47:0] held = '0;
   logic [47:0] bias_v = '0;

   task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s: bound expired at cycle %0d", name, cyc);
   endtask

   // Monitor: per-cycle port relations, CEP pulse count, scoreboard pops on result.
   initial begin
      exp_t e;
      forever begin
         @(posedge CLK);
         #2;
         cyc++;
         if (DSP_CEP) cep_total++;
         check("dsp_ceab", 48'(DSP_CEAB), 48'(IN_VALID & IN_READY));
         check("dsp_rstp", 48'(DSP_RSTP), 48'(RST));
         check("dsp_a", 48'(DSP_A), 48'(IN_A));
         check("dsp_ceopmode", 48'(DSP_CEOPMODE), 48'd1);
         if (RES_VALID) begin
            if (!seen) begin
               seen = 1'b1;
               if (sb.size() == 0) begin
                  fail_now("unexpected_result");
               end else begin
                  e = sb.pop_front();
                  held = e.data;
                  check("res_data", RES_DATA, e.data);
                  check("res_latency", 48'(cyc), 48'(e.cyc));
                  check("cep_pulses", 48'(cep_total), 48'(e.cep));
               end
            end else begin
               check("res_hold", RES_DATA, held);
            end
         end else begin
            seen = 1'b0;
         end
      end
   end

   function automatic logic [17:0] pick_operand();
      int unsigned r;
      logic [31:0] w;
      r = $urandom_range(0, 5);
      w = $urandom();
      if (r == 0) return 18'h20000;
      if (r == 1) return 18'h1FFFF;
      return w[17:0];
   endfunction

   // Issue one job (operands from qa/qb), push its expected result, then retire it.
   task automatic run_job(input int len, input int gap, input int hold);
      longint acc_l;
      int     last, t, g, base;
      exp_t   e;
      acc_l = 0;
`ifdef DSP_MAC_BIAS_EN
      BIAS  = bias_v;
      acc_l = longint'($signed(bias_v));
`endif
      base  = cep_total;
      START = 1'b1;
      LEN   = LEN_W'(len);
      if (len == 0) begin
         e.data = acc_l[47:0];
         e.cyc  = cyc + 1;
         e.cep  = base;
         sb.push_back(e);
         @(negedge CLK);
         START = 1'b0;
      end else begin
         @(negedge CLK);
         START = 1'b0;
         last  = 0;
         for (int i = 0; i < len; i++) begin
            g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            if (i > 0) repeat (g) @(negedge CLK);
            IN_A = qa[i];
            IN_B = qb[i];
            IN_VALID = 1'b1;
            t = 0;
            while (!IN_READY && t < 20) begin
               @(negedge CLK);
               t++;
            end
            if (!IN_READY) fail_now("in_ready_wait");
            last  = cyc + 1;
            acc_l = acc_l + longint'($signed(qa[i])) * longint'($signed(qb[i]));
            @(negedge CLK);
            IN_VALID = 1'b0;
            check("dsp_opmode", 48'(DSP_OPMODE), (i == 0) ? 48'(FIRST_OPM) : 48'h09);
         end
         e.data = acc_l[47:0];
         e.cyc  = last + 3;
         e.cep  = base + len;
         sb.push_back(e);
      end
      t = 0;
      while (!RES_VALID && t < 60) begin
         @(negedge CLK);
         t++;
      end
      if (!RES_VALID) fail_now("res_valid_wait");
      // Stall the consumer; START must be ignored and no operands taken.
      for (int h = 0; h < hold; h++) begin
         check("in_ready_done", 48'(IN_READY), 48'd0);
         check("busy_done", 48'(BUSY), 48'd1);
         START = 1'b1;
         LEN   = LEN_W'(3);
         @(negedge CLK);
      end
      RES_READY = 1'b1;
      @(negedge CLK);
      RES_READY = 1'b0;
      START     = 1'b0;
      check("busy_after_hs", 48'(BUSY), 48'd0);
      check("res_valid_after_hs", 48'(RES_VALID), 48'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [63:0] w64;
      RST = 1'b1; START = 1'b0; LEN = '0; IN_A = '0; IN_B = '0;
      IN_VALID = 1'b0; RES_READY = 1'b0;
`ifdef DSP_MAC_BIAS_EN
      BIAS = '0;
`endif
      repeat (3) @(negedge CLK);
      check("rst_busy", 48'(BUSY), 48'd0);
      check("rst_in_ready", 48'(IN_READY), 48'd0);
      check("rst_res_valid", 48'(RES_VALID), 48'd0);
      check("rst_res_data", RES_DATA, 48'd0);
      check("rst_opmode", 48'(DSP_OPMODE), 48'd0);
      check("rst_cep", 48'(DSP_CEP), 48'd0);
      RST = 1'b0;

      // Gapless four-term job, result held five cycles.
      qa = '{18'd3, -18'sd2, 18'd100, 18'd1};
      qb = '{18'd5, 18'd7, 18'd100, -18'sd1};
      run_job(4, 0, 5);

      // Full-scale operands with two-cycle bubbles.
      qa = '{18'h1FFFF, 18'h1FFFF, 18'h1FFFF};
      qb = '{18'h1FFFF, 18'h1FFFF, 18'h1FFFF};
      run_job(3, 2, 0);

      // Empty job.
      run_job(0, 0, 1);

      // Reset in the middle of a five-term job.
      START = 1'b1;
      LEN   = LEN_W'(5);
      @(negedge CLK);
      START = 1'b0;
      for (int i = 0; i < 2; i++) begin
         IN_A = 18'(i + 7);
         IN_B = 18'(i + 9);
         IN_VALID = 1'b1;
         check("in_ready_run", 48'(IN_READY), 48'd1);
         @(negedge CLK);
      end
      IN_VALID = 1'b0;
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      check("abort_busy", 48'(BUSY), 48'd0);
      check("abort_res_valid", 48'(RES_VALID), 48'd0);
      check("abort_opmode", 48'(DSP_OPMODE), 48'd0);
      check("abort_cep", 48'(DSP_CEP), 48'd0);
      qa = '{18'd2};
      qb = '{18'd2};
      run_job(1, 0, 0);

`ifdef DSP_MAC_BIAS_EN
      bias_v = -48'sd10;
      qa = '{18'd4, 18'd1};
      qb = '{18'd4, 18'd1};
      run_job(2, 0, 0);
      run_job(0, 0, 0);
`endif

      for (int j = 0; j < 20; j++) begin
         n = $urandom_range(0, 8);
         qa.delete();
         qb.delete();
         for (int i = 0; i < n; i++) begin
            qa.push_back(pick_operand());
            qb.push_back(pick_operand());
         end
`ifdef DSP_MAC_BIAS_EN
         w64 = {$urandom(), $urandom()};
         bias_v = w64[47:0];
`else
         w64 = '0;
`endif
         run_job(n, -1, int'($urandom_range(0, 3)) + int'(w64[0]));
      end

      repeat (5) @(negedge CLK);
      if (sb.size() != 0) fail_now("scoreboard_leftover");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
